// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter sharing one UART TX path
//
// Purpose:
//   N_REQ client requesters share the single write port of a UART transmit FIFO.
//   A grant is given round-robin and held for a whole packet: it ends on the
//   requester's last byte, after MAX_PKT bytes, or when the requester drops req.
//   Each byte takes a SEND cycle (strobe issued) followed by a GAP cycle, so that
//   tx_full has settled before the next write. All outputs are registered.
//
// Optional feature (macro UART_ARB_TAG_EN):
//   When defined, every grant starts with a header byte 8'hA0 | g written through
//   a TAG state (no req_ack, not counted toward MAX_PKT).
//
// Ports:
//   clk       in   system clock
//   Reset     in   asynchronous active-high reset
//   req       in   [N_REQ]        per-requester byte valid, held until req_ack
//   req_data  in   [N_REQ*DATA_W] byte of requester i at [i*DATA_W +: DATA_W]
//   req_last  in   [N_REQ]        marks req_data as last byte of packet
//   req_ack   out  [N_REQ]        one-cycle pulse, byte of requester i taken
//   grant     out  [N_REQ]        one-hot owner of the TX path, 0 when idle
//   wr_uart   out                 one-cycle write strobe to the UART TX FIFO
//   w_data    out  [DATA_W]       byte to the UART, valid while wr_uart=1
//   tx_full   in                  UART TX FIFO full
//   busy      out                 high whenever the FSM is not idle

module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int MAX_PKT = 16
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ack,
  output logic [N_REQ-1:0]          grant,
  output logic                      wr_uart,
  output logic [DATA_W-1:0]         w_data,
  input  logic                      tx_full,
  output logic                      busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_PKT + 1);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_TAG} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
`endif

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                last_q, last_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    req_ack_q, req_ack_d;
  logic                wr_uart_q, wr_uart_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                busy_q, busy_d;

  // Round-robin pick: first requester at or above rr_ptr, wrapping.
  logic                found;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W-1:0]    k_idx;
  int                  k;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    k     = 0;
    k_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k     = (int'(rr_ptr_q) + i) % N_REQ;
      k_idx = IDX_W'(k);
      if (!found && req[k_idx]) begin
        found = 1'b1;
        pick  = k_idx;
      end
    end
  end

  logic release_grant;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gidx_d        = gidx_q;
    byte_cnt_d    = byte_cnt_q;
    last_d        = last_q;
    grant_d       = grant_q;
    req_ack_d     = '0;
    wr_uart_d     = 1'b0;
    w_data_d      = w_data_q;
    release_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          gidx_d     = pick;
          grant_d    = N_REQ'(1) << pick;
          byte_cnt_d = '0;
          last_d     = 1'b0;
`ifdef UART_ARB_TAG_EN
          state_d    = S_TAG;
`else
          state_d    = S_SEND;
`endif
        end
      end

`ifdef UART_ARB_TAG_EN
      // Header byte identifies the owner; it carries no requester data, so no ack.
      S_TAG: begin
        if (!tx_full) begin
          wr_uart_d = 1'b1;
          w_data_d  = DATA_W'(8'hA0 | 8'(gidx_q));
          last_d    = 1'b0;
          state_d   = S_GAP;
        end
      end
`endif

      S_SEND: begin
        if (!req[gidx_q]) begin
          release_grant = 1'b1;
        end else if (!tx_full) begin
          wr_uart_d         = 1'b1;
          w_data_d          = req_data[int'(gidx_q)*DATA_W +: DATA_W];
          req_ack_d[gidx_q] = 1'b1;
          byte_cnt_d        = byte_cnt_q + 1'b1;
          last_d            = req_last[gidx_q];
          state_d           = S_GAP;
        end
      end

      // One dead cycle so tx_full reflects the write just issued.
      S_GAP: begin
        if (last_q || (byte_cnt_q == CNT_W'(MAX_PKT))) begin
          release_grant = 1'b1;
        end else begin
          state_d = S_SEND;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (release_grant) begin
      grant_d  = '0;
      rr_ptr_d = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
      state_d  = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      byte_cnt_q <= '0;
      last_q     <= 1'b0;
      grant_q    <= '0;
      req_ack_q  <= '0;
      wr_uart_q  <= 1'b0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      req_ack_q  <= req_ack_d;
      wr_uart_q  <= wr_uart_d;
      w_data_q   <= w_data_d;
      busy_q     <= busy_d;
    end
  end

  assign grant   = grant_q;
  assign req_ack = req_ack_q;
  assign wr_uart = wr_uart_q;
  assign w_data  = w_data_q;
  assign busy    = busy_q;

endmodule
